// File: rtl/l2_mem_pkg.sv
// Shared types and helpers for the L2-to-AXI memory bridge.
package l2_mem_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2,
        R_DONE = 2'd3
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_DATA = 2'd2,
        W_B    = 2'd3
    } w_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'd2;

    // Line width in bits for a given log2(words per line).
    function automatic int line_width(input int ow);
        return 32 * (1 << ow);
    endfunction

    // Number of 32-bit words (= burst beats) per line.
    function automatic int words_per_line(input int ow);
        return 1 << ow;
    endfunction

    // Clear the in-line byte offset so a cached burst starts on the line boundary.
    function automatic logic [31:0] line_align(input logic [31:0] addr, input int ow);
        logic [31:0] mask;
        mask = (32'd1 << (ow + 2)) - 32'd1;
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/l2_line_buf.sv
// Line-wide word buffer: whole-line load for write-backs, per-word fill for refills,
// per-word read for write bursts. One instance is shared by the read and write paths.
module l2_line_buf
    import l2_mem_pkg::*;
#(
    parameter int  OW    = 3,
    localparam int WORDS = words_per_line(OW),
    localparam int LINE  = line_width(OW)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            clr_i,
    input  logic            load_i,
    input  logic [LINE-1:0] line_i,
    input  logic            we_i,
    input  logic [OW-1:0]   idx_i,
    input  logic [31:0]     word_i,
    output logic [LINE-1:0] line_o,
    output logic [31:0]     word_o
);

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            logic [31:0] word_q;

            // Each word: load from the L2 line, clear before a refill, or take one beat.
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    word_q <= '0;
                end else if (load_i) begin
                    word_q <= line_i[gi*32 +: 32];
                end else if (clr_i) begin
                    word_q <= '0;
                end else if (we_i && (idx_i == OW'(gi))) begin
                    word_q <= word_i;
                end
            end

            assign line_o[gi*32 +: 32] = word_q;
        end
    endgenerate

    assign word_o = line_o[32*idx_i +: 32];

endmodule

// File: rtl/l2_mem_axi_bridge.sv
// L2cache memory port to 32-bit AXI4 bridge: line refills/write-backs as INCR bursts,
// uncached (SUC) accesses as single beats. One transaction in flight at a time.
module l2_mem_axi_bridge
    import l2_mem_pkg::*;
#(
    parameter int  L2_offset_width = 3,
    localparam int LINE            = line_width(L2_offset_width)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [31:0]     addr_l2cache_mem_r,
    input  logic [31:0]     addr_l2cache_mem_w,
    input  logic [LINE-1:0] dout_l2cache_mem,
    input  logic            l2cache_mem_req_r,
    input  logic            l2cache_mem_req_w,
    input  logic            l2cache_mem_rdy,
    input  logic            l2cache_mem_SUC,
    input  logic [3:0]      l2cache_mem_wstrb,
    input  logic [1:0]      l2cache_mem_size,
    output logic            mem_l2cache_addrOK_r,
    output logic            mem_l2cache_addrOK_w,
    output logic [LINE-1:0] din_mem_l2cache,
    output logic            mem_l2cache_dataOK,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic            awvalid,
    input  logic            awready,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    localparam int         OW       = L2_offset_width;
    localparam logic [7:0] LINE_LEN = 8'(words_per_line(OW) - 1);

    r_state_e      r_state_q;
    w_state_e      w_state_q;
    logic [31:0]   araddr_q, awaddr_q;
    logic [7:0]    arlen_q, awlen_q;
    logic [2:0]    arsize_q, awsize_q;
    logic [3:0]    wstrb_q;
    logic          arvalid_q, rready_q, dataok_q;
    logic          awvalid_q, wvalid_q, bready_q;
    logic [OW-1:0] rbeat_q, wbeat_q;

    logic both_idle, accept_r, accept_w;
    logic r_last_beat, aw_hs, w_hs, w_last, aw_done, w_done;
    logic [OW-1:0] buf_idx;
    logic [31:0]   buf_word;
    logic [LINE-1:0] buf_line;

    // Responses carry no information we act on; collected only to keep them visibly consumed.
    logic unused_axi_resp;
    assign unused_axi_resp = ^{rresp, rlast, bresp};

    // Writes win a same-cycle tie, and no read starts until a write's B response is in.
    assign both_idle = (r_state_q == R_IDLE) && (w_state_q == W_IDLE);
    assign accept_w  = l2cache_mem_req_w & both_idle;
    assign accept_r  = l2cache_mem_req_r & ~l2cache_mem_req_w & both_idle;

    assign r_last_beat = (rbeat_q == arlen_q[OW-1:0]);
    assign aw_hs       = awvalid_q & awready;
    assign w_hs        = wvalid_q & wready;
    assign w_last      = (wbeat_q == awlen_q[OW-1:0]);
    assign aw_done     = ~awvalid_q | aw_hs;
    assign w_done      = ~wvalid_q | (w_hs & w_last);

    // Read FSM: issue AR, collect beats by count (not rlast), hold the line until L2 takes it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state_q <= R_IDLE;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            dataok_q  <= 1'b0;
            rbeat_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (accept_r) begin
                        if (l2cache_mem_SUC) begin
                            araddr_q <= addr_l2cache_mem_r;
                            arlen_q  <= 8'd0;
                            arsize_q <= {1'b0, l2cache_mem_size};
                        end else begin
                            araddr_q <= line_align(addr_l2cache_mem_r, OW);
                            arlen_q  <= LINE_LEN;
                            arsize_q <= AXI_SIZE_4B;
                        end
                        arvalid_q <= 1'b1;
                        rbeat_q   <= '0;
                        r_state_q <= R_AR;
                    end
                end
                R_AR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid) begin
                        if (r_last_beat) begin
                            rready_q  <= 1'b0;
                            dataok_q  <= 1'b1;
                            r_state_q <= R_DONE;
                        end else begin
                            rbeat_q <= rbeat_q + OW'(1);
                        end
                    end
                end
                R_DONE: begin
                    if (l2cache_mem_rdy) begin
                        dataok_q  <= 1'b0;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // Write FSM: AW and W run independently from the same cycle; B is waited for once both finish.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_state_q <= W_IDLE;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            wbeat_q   <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (accept_w) begin
                        if (l2cache_mem_SUC) begin
                            awaddr_q <= addr_l2cache_mem_w;
                            awlen_q  <= 8'd0;
                            awsize_q <= {1'b0, l2cache_mem_size};
                            wstrb_q  <= l2cache_mem_wstrb;
                        end else begin
                            awaddr_q <= line_align(addr_l2cache_mem_w, OW);
                            awlen_q  <= LINE_LEN;
                            awsize_q <= AXI_SIZE_4B;
                            wstrb_q  <= 4'hF;
                        end
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        wbeat_q   <= '0;
                        w_state_q <= W_AW;
                    end
                end
                W_AW, W_DATA: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                    end
                    if (w_hs) begin
                        if (w_last) begin
                            wvalid_q <= 1'b0;
                        end else begin
                            wbeat_q <= wbeat_q + OW'(1);
                        end
                    end
                    if (aw_done && w_done) begin
                        bready_q  <= 1'b1;
                        w_state_q <= W_B;
                    end else if (aw_done) begin
                        w_state_q <= W_DATA;
                    end
                end
                W_B: begin
                    if (bvalid) begin
                        bready_q  <= 1'b0;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    assign buf_idx = (w_state_q != W_IDLE) ? wbeat_q : rbeat_q;

    l2_line_buf #(
        .OW (OW)
    ) u_line_buf (
        .clk    (clk),
        .rstn   (rstn),
        .clr_i  (accept_r),
        .load_i (accept_w),
        .line_i (dout_l2cache_mem),
        .we_i   (rvalid & rready_q),
        .idx_i  (buf_idx),
        .word_i (rdata),
        .line_o (buf_line),
        .word_o (buf_word)
    );

    assign mem_l2cache_addrOK_r = accept_r;
    assign mem_l2cache_addrOK_w = accept_w;
    assign din_mem_l2cache      = buf_line;
    assign mem_l2cache_dataOK   = dataok_q;

    assign araddr  = araddr_q;
    assign arlen   = arlen_q;
    assign arsize  = arsize_q;
    assign arburst = AXI_BURST_INCR;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

    assign awaddr  = awaddr_q;
    assign awlen   = awlen_q;
    assign awsize  = awsize_q;
    assign awburst = AXI_BURST_INCR;
    assign awvalid = awvalid_q;
    assign wdata   = buf_word;
    assign wstrb   = wstrb_q;
    assign wlast   = wvalid_q & w_last;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;

endmodule

// File: tb/tb_l2_mem_axi_bridge.sv
// Directed bench for l2_mem_axi_bridge: table of read/write transactions plus hand-written
// sequences for write/read ordering, AXI stalls and reset in the middle of a burst.
module tb_l2_mem_axi_bridge;

    localparam int OW   = 3;
    localparam int LINE = 32 * (1 << OW);

    logic            clk;
    logic            rstn;
    logic [31:0]     addr_l2cache_mem_r, addr_l2cache_mem_w;
    logic [LINE-1:0] dout_l2cache_mem;
    logic            l2cache_mem_req_r, l2cache_mem_req_w, l2cache_mem_rdy, l2cache_mem_SUC;
    logic [3:0]      l2cache_mem_wstrb;
    logic [1:0]      l2cache_mem_size;
    logic            mem_l2cache_addrOK_r, mem_l2cache_addrOK_w, mem_l2cache_dataOK;
    logic [LINE-1:0] din_mem_l2cache;
    logic [31:0]     araddr, awaddr, rdata, wdata;
    logic [7:0]      arlen, awlen;
    logic [2:0]      arsize, awsize;
    logic [1:0]      arburst, awburst, rresp, bresp;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]      wstrb;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    typedef struct {
        bit          wr;
        bit          suc;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strb;
        logic [31:0] base;
        logic [31:0] exp_addr;
        logic [7:0]  exp_len;
        logic [2:0]  exp_size;
        logic [3:0]  exp_strb;
        int          hold;
    } vec_t;

    vec_t vt [7];

    l2_mem_axi_bridge #(.L2_offset_width(OW)) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .addr_l2cache_mem_r   (addr_l2cache_mem_r),
        .addr_l2cache_mem_w   (addr_l2cache_mem_w),
        .dout_l2cache_mem     (dout_l2cache_mem),
        .l2cache_mem_req_r    (l2cache_mem_req_r),
        .l2cache_mem_req_w    (l2cache_mem_req_w),
        .l2cache_mem_rdy      (l2cache_mem_rdy),
        .l2cache_mem_SUC      (l2cache_mem_SUC),
        .l2cache_mem_wstrb    (l2cache_mem_wstrb),
        .l2cache_mem_size     (l2cache_mem_size),
        .mem_l2cache_addrOK_r (mem_l2cache_addrOK_r),
        .mem_l2cache_addrOK_w (mem_l2cache_addrOK_w),
        .din_mem_l2cache      (din_mem_l2cache),
        .mem_l2cache_dataOK   (mem_l2cache_dataOK),
        .araddr               (araddr),
        .arlen                (arlen),
        .arsize               (arsize),
        .arburst              (arburst),
        .arvalid              (arvalid),
        .arready              (arready),
        .rdata                (rdata),
        .rresp                (rresp),
        .rlast                (rlast),
        .rvalid               (rvalid),
        .rready               (rready),
        .awaddr               (awaddr),
        .awlen                (awlen),
        .awsize               (awsize),
        .awburst              (awburst),
        .awvalid              (awvalid),
        .awready              (awready),
        .wdata                (wdata),
        .wstrb                (wstrb),
        .wlast                (wlast),
        .wvalid               (wvalid),
        .wready               (wready),
        .bresp                (bresp),
        .bvalid               (bvalid),
        .bready               (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
        return l;
    endfunction

    task automatic do_read(input logic [31:0] addr, input bit suc, input logic [1:0] size,
                           input logic [31:0] base, input logic [31:0] exp_addr,
                           input logic [7:0] exp_len, input logic [2:0] exp_size,
                           input int ar_delay, input int hold);
        bit bad;
        logic [255:0] exp_line;
        addr_l2cache_mem_r = addr;
        l2cache_mem_SUC    = suc;
        l2cache_mem_size   = size;
        l2cache_mem_req_r  = 1'b1;
        #1;
        check("rd_addrOK_r", 256'(mem_l2cache_addrOK_r), 256'(1));
        tick;
        l2cache_mem_req_r  = 1'b0;
        addr_l2cache_mem_r = 32'hDEAD_0000;
        l2cache_mem_SUC    = 1'b0;
        check("rd_ar_payload", 256'({arvalid, araddr, arlen, arsize, arburst}),
              256'({1'b1, exp_addr, exp_len, exp_size, 2'b01}));
        bad = 1'b0;
        for (int i = 0; i < ar_delay; i++) begin
            tick;
            if (!arvalid || araddr !== exp_addr || arlen !== exp_len) bad = 1'b1;
        end
        check("rd_ar_stall_hold", 256'(bad), 256'(0));
        arready = 1'b1;
        tick;
        arready = 1'b0;
        bad = 1'b0;
        for (int k = 0; k <= int'(exp_len); k++) begin
            if (!rready || mem_l2cache_dataOK) bad = 1'b1;
            rvalid = 1'b1;
            rdata  = base + 32'(k);
            rlast  = (k == int'(exp_len));
            tick;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rdata  = 32'h0;
        check("rd_rready_beats", 256'(bad), 256'(0));
        exp_line = suc ? {224'h0, base} : make_line(base);
        check("rd_dataOK_rready", 256'({mem_l2cache_dataOK, rready}), 256'(2'b10));
        check("rd_din", din_mem_l2cache, exp_line);
        bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick;
            if (!mem_l2cache_dataOK || din_mem_l2cache !== exp_line) bad = 1'b1;
        end
        check("rd_hold_until_rdy", 256'(bad), 256'(0));
        l2cache_mem_rdy = 1'b1;
        tick;
        l2cache_mem_rdy = 1'b0;
        check("rd_dataOK_clear", 256'(mem_l2cache_dataOK), 256'(0));
        $display("read  addr=%h suc=%0d araddr=%h arlen=%0d done", addr, suc, exp_addr, exp_len);
    endtask

    task automatic do_write(input logic [31:0] addr, input bit suc, input logic [1:0] size,
                            input logic [3:0] strb, input logic [31:0] base,
                            input logic [31:0] exp_addr, input logic [7:0] exp_len,
                            input logic [2:0] exp_size, input logic [3:0] exp_strb,
                            input bit toggle, input int b_delay, input bit with_rd);
        logic [255:0] line;
        logic [36:0]  prev_w;
        bit prev_wpend, unstable, bad_dok, bad_ovl, budget_ok, bad, aw_rdy, w_rdy;
        int beat, aw_cnt;
        line = make_line(base);
        prev_w = '0;
        prev_wpend = 1'b0; unstable = 1'b0; bad_dok = 1'b0; bad_ovl = 1'b0; budget_ok = 1'b0;
        beat = 0; aw_cnt = 0;
        addr_l2cache_mem_w = addr;
        dout_l2cache_mem   = line;
        l2cache_mem_SUC    = suc;
        l2cache_mem_size   = size;
        l2cache_mem_wstrb  = strb;
        l2cache_mem_req_w  = 1'b1;
        if (with_rd) l2cache_mem_req_r = 1'b1;
        #1;
        check("wr_addrOK_w_r", 256'({mem_l2cache_addrOK_w, mem_l2cache_addrOK_r}), 256'(2'b10));
        tick;
        l2cache_mem_req_w  = 1'b0;
        dout_l2cache_mem   = ~line;
        addr_l2cache_mem_w = ~addr;
        l2cache_mem_wstrb  = ~strb;
        l2cache_mem_size   = ~size;
        l2cache_mem_SUC    = ~suc;
        check("wr_aw_w_start", 256'({awvalid, wvalid, awaddr, awlen, awsize, awburst}),
              256'({2'b11, exp_addr, exp_len, exp_size, 2'b01}));
        for (int c = 0; c < 100; c++) begin
            if (mem_l2cache_dataOK) bad_dok = 1'b1;
            if (mem_l2cache_addrOK_r || arvalid) bad_ovl = 1'b1;
            if (prev_wpend && wvalid && {wdata, wstrb, wlast} !== prev_w) unstable = 1'b1;
            aw_rdy = toggle ? (c >= 3) : 1'b1;
            w_rdy  = toggle ? (c % 2 == 1) : 1'b1;
            if (wvalid && w_rdy) begin
                check("wr_beat", 256'({wdata, wstrb, wlast}),
                      256'({line[beat*32 +: 32], exp_strb, 1'(beat == int'(exp_len))}));
                beat++;
            end
            if (awvalid && aw_rdy) aw_cnt++;
            prev_wpend = wvalid && !w_rdy;
            prev_w     = {wdata, wstrb, wlast};
            awready = aw_rdy;
            wready  = w_rdy;
            tick;
            if (beat == int'(exp_len) + 1 && aw_cnt >= 1) begin
                budget_ok = 1'b1;
                break;
            end
        end
        awready = 1'b0;
        wready  = 1'b0;
        check("wr_done_in_budget", 256'(budget_ok), 256'(1));
        check("wr_aw_once", 256'(aw_cnt), 256'(1));
        check("wr_enter_B", 256'({awvalid, wvalid, bready}), 256'(3'b001));
        bad = 1'b0;
        for (int i = 0; i < b_delay; i++) begin
            if (!bready || mem_l2cache_addrOK_r || arvalid || mem_l2cache_dataOK) bad = 1'b1;
            tick;
        end
        bvalid = 1'b1;
        #1;
        if (mem_l2cache_addrOK_r) bad = 1'b1;
        tick;
        bvalid = 1'b0;
        check("wr_B_wait", 256'(bad), 256'(0));
        check("wr_bready_clear", 256'(bready), 256'(0));
        check("wr_no_dataOK", 256'(bad_dok), 256'(0));
        check("wr_no_read_overlap", 256'(bad_ovl), 256'(0));
        check("wr_w_stable", 256'(unstable), 256'(0));
        if (with_rd) check("raw_addrOK_r_after_B", 256'(mem_l2cache_addrOK_r), 256'(1));
        l2cache_mem_SUC  = 1'b0;
        l2cache_mem_size = 2'd0;
        $display("write addr=%h suc=%0d awaddr=%h awlen=%0d beats=%0d done", addr, suc, exp_addr, exp_len, beat);
    endtask

    initial begin
        vt[0] = '{1'b0, 1'b0, 32'h1000_0024, 2'd0, 4'h0, 32'h0000_00A0, 32'h1000_0020, 8'd7, 3'd2, 4'hF, 3};
        vt[1] = '{1'b0, 1'b1, 32'h1FE0_01F5, 2'd0, 4'h0, 32'h0000_0055, 32'h1FE0_01F5, 8'd0, 3'd0, 4'hF, 0};
        vt[2] = '{1'b1, 1'b0, 32'h2000_0040, 2'd2, 4'h0, 32'h0000_00B0, 32'h2000_0040, 8'd7, 3'd2, 4'hF, 0};
        vt[3] = '{1'b1, 1'b1, 32'h1FE0_0102, 2'd1, 4'hC, 32'h1234_ABCD, 32'h1FE0_0102, 8'd0, 3'd1, 4'hC, 0};
        vt[4] = '{1'b0, 1'b1, 32'h1FE0_0100, 2'd2, 4'h0, 32'hDEAD_BEEF, 32'h1FE0_0100, 8'd0, 3'd2, 4'hF, 0};
        vt[5] = '{1'b0, 1'b0, 32'h3000_003C, 2'd0, 4'h0, 32'h0000_3000, 32'h3000_0020, 8'd7, 3'd2, 4'hF, 1};
        vt[6] = '{1'b1, 1'b0, 32'h2000_005C, 2'd0, 4'h0, 32'h0000_9000, 32'h2000_0040, 8'd7, 3'd2, 4'hF, 0};

        rstn = 1'b0;
        addr_l2cache_mem_r = '0; addr_l2cache_mem_w = '0; dout_l2cache_mem = '0;
        l2cache_mem_req_r = 1'b0; l2cache_mem_req_w = 1'b0; l2cache_mem_rdy = 1'b0;
        l2cache_mem_SUC = 1'b0; l2cache_mem_wstrb = '0; l2cache_mem_size = '0;
        arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;

        @(negedge clk);
        tick;
        tick;
        check("reset_valids", 256'({arvalid, rready, awvalid, wvalid, bready, mem_l2cache_dataOK}), 256'(0));
        check("reset_din", din_mem_l2cache, 256'(0));
        rstn = 1'b1;
        $display("reset released");

        for (int i = 0; i < 7; i++) begin
            if (vt[i].wr)
                do_write(vt[i].addr, vt[i].suc, vt[i].size, vt[i].strb, vt[i].base, vt[i].exp_addr,
                         vt[i].exp_len, vt[i].exp_size, vt[i].exp_strb, 1'b0, 0, 1'b0);
            else
                do_read(vt[i].addr, vt[i].suc, vt[i].size, vt[i].base, vt[i].exp_addr,
                        vt[i].exp_len, vt[i].exp_size, 0, vt[i].hold);
        end

        // Simultaneous requests: write first, read held off until after the B handshake.
        addr_l2cache_mem_r = 32'h2000_0080;
        do_write(32'h2000_0080, 1'b0, 2'd0, 4'h0, 32'h0000_00C0, 32'h2000_0080, 8'd7, 3'd2, 4'hF,
                 1'b0, 2, 1'b1);
        do_read(32'h2000_0080, 1'b0, 2'd0, 32'h0000_00E0, 32'h2000_0080, 8'd7, 3'd2, 0, 0);

        // AXI stalls: slow arready, toggling wready, late bvalid.
        do_read(32'h1000_0200, 1'b0, 2'd0, 32'h0000_7700, 32'h1000_0200, 8'd7, 3'd2, 5, 2);
        do_write(32'h2000_0100, 1'b0, 2'd0, 4'h0, 32'h0000_5500, 32'h2000_0100, 8'd7, 3'd2, 4'hF,
                 1'b1, 10, 1'b0);

        // Reset during beat 3 of a refill, then an immediate new read.
        addr_l2cache_mem_r = 32'h1000_0100;
        l2cache_mem_req_r  = 1'b1;
        tick;
        l2cache_mem_req_r  = 1'b0;
        arready = 1'b1;
        tick;
        arready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rvalid = 1'b1;
            rdata  = 32'h0000_0F00 + 32'(k);
            tick;
        end
        rdata = 32'h0000_0F03;
        rstn  = 1'b0;
        tick;
        rstn   = 1'b1;
        rvalid = 1'b0;
        check("rst_mid_outputs", 256'({arvalid, rready, awvalid, wvalid, bready, mem_l2cache_dataOK,
                                       mem_l2cache_addrOK_r, mem_l2cache_addrOK_w}), 256'(0));
        check("rst_mid_din", din_mem_l2cache, 256'(0));
        $display("mid-burst reset applied");
        do_read(32'h1000_0104, 1'b0, 2'd0, 32'h0000_4400, 32'h1000_0100, 8'd7, 3'd2, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
